// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned MAX_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/prog_loader_addr_sum_counter.sv
// Word index counter paired with a wrapping accumulator of the words it has seen.
module prog_loader_addr_sum_counter
    import prog_loader_pkg::*;
#(
    parameter int unsigned CNT_W = 11,
    parameter int unsigned SUM_W = ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SUM_W-1:0] data,
    output logic [CNT_W-1:0] idx,
    output logic [SUM_W-1:0] sum
);

    // Clear has priority; each enabled cycle advances the index and adds the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            sum <= '0;
        end else if (clr) begin
            idx <= '0;
            sum <= '0;
        end else if (en) begin
            idx <= idx + CNT_W'(1);
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams words into memory from a base address, reads them back to verify
// the sum, and releases the processor only after a clean load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned CNT_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [31:0]       mem_data_in,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [31:0]       mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic              cpu_run
);

    localparam int unsigned EXT_W = ADDR_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic              error_q;

    logic              start_ok;
    logic              load_hs;
    logic              verify_en;
    logic              range_bad;
    logic [EXT_W-1:0]  end_addr;
    logic [CNT_W-1:0]  count_last;
    logic [CNT_W-1:0]  load_idx;
    logic [CNT_W-1:0]  read_idx;
    logic [31:0]       load_sum;
    logic [31:0]       read_sum;
    logic [31:0]       read_sum_final;

    // Handshake qualifiers and the no-wrap range check on the requested region.
    assign start_ok       = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign load_hs        = (state == ST_LOAD) && in_valid;
    assign verify_en      = (state == ST_VERIFY);
    assign end_addr       = {1'b0, base_addr} + EXT_W'(word_count);
    assign range_bad      = end_addr > EXT_W'(MAX_WORDS);
    assign count_last     = count_q - CNT_W'(1);
    assign read_sum_final = read_sum + mem_data_out;

    // Load side: one index step and one accumulate per accepted stream word.
    prog_loader_addr_sum_counter #(
        .CNT_W (CNT_W),
        .SUM_W (32)
    ) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (load_hs),
        .data  (in_data),
        .idx   (load_idx),
        .sum   (load_sum)
    );

    // Readback side: one index step and one accumulate per verify cycle.
    prog_loader_addr_sum_counter #(
        .CNT_W (CNT_W),
        .SUM_W (32)
    ) u_read_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (verify_en),
        .data  (mem_data_out),
        .idx   (read_idx),
        .sum   (read_sum)
    );

    // Load sequencer: latch the request, stream in, read back, then report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            base_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        error_q <= 1'b0;
                        if (range_bad) begin
                            error_q <= 1'b1;
                            state   <= ST_DONE;
                        end else if (word_count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid && (load_idx == count_last)) begin
                        state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (read_idx == count_last) begin
                        error_q <= (read_sum_final != load_sum);
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status and memory-port outputs, all decoded from registered state.
    assign in_ready          = (state == ST_LOAD);
    assign mem_write_enable  = load_hs;
    assign mem_write_address = (state == ST_LOAD) ? (base_q + ADDR_W'(load_idx)) : '0;
    assign mem_data_in       = (state == ST_LOAD) ? in_data : '0;
    assign mem_read_address  = verify_en ? (base_q + ADDR_W'(read_idx)) : '0;
    assign busy              = (state == ST_LOAD) || (state == ST_VERIFY);
    assign done              = (state == ST_DONE);
    assign error             = error_q;
    assign cpu_run           = (state == ST_DONE) && !error_q;
    assign checksum          = load_sum;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized bench for prog_loader with a behavioural memory
// and a reference model built from sums and expected write lists.
module tb_prog_loader;

    localparam int unsigned MAX_WORDS = 1024;
    localparam int unsigned CNT_W     = 11;
    localparam int          TIMEOUT   = 5000;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [31:0]       base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              mem_write_enable;
    logic [31:0]       mem_write_address;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_read_address;
    logic [31:0]       mem_data_out;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       checksum;
    logic              cpu_run;

    logic [31:0] mem [0:MAX_WORDS-1];
    logic [63:0] wr_log [$];
    logic [31:0] words [$];
    int          corrupt_addr = -1;
    int          checks   = 0;
    int          failures = 0;

    prog_loader #(
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_read_address  (mem_read_address),
        .mem_data_out      (mem_data_out),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .checksum          (checksum),
        .cpu_run           (cpu_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write (optionally corrupting one address), combinational read.
    assign mem_data_out = (mem_read_address < 32'(MAX_WORDS)) ? mem[mem_read_address[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write_enable) begin
            if (int'(mem_write_address) == corrupt_addr)
                mem[mem_write_address[9:0]] <= mem_data_in ^ 32'h0000_0100;
            else
                mem[mem_write_address[9:0]] <= mem_data_in;
            wr_log.push_back({mem_write_address, mem_data_in});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one load request using the global word list and checks the outcome.
    task automatic run_case(input string name, input logic [31:0] base, input int n,
                            input bit rnd, input logic [15:0] pat, input int patlen);
        logic [31:0] exp_sum;
        logic [63:0] e;
        bit          range_err;
        bit          exp_err;
        int          sent;
        int          cyc;
        int          last_hs;
        int          exp_done;
        int          exp_writes;

        exp_sum = 32'h0;
        for (int i = 0; i < n; i++) exp_sum += words[i];
        range_err = (longint'(base) + longint'(n)) > longint'(MAX_WORDS);
        exp_err   = range_err;
        if (range_err) exp_sum = 32'h0;
        else
            for (int i = 0; i < n; i++)
                if (longint'(base) + longint'(i) == longint'(corrupt_addr)) exp_err = 1'b1;
        exp_writes = range_err ? 0 : n;

        @(negedge clk);
        wr_log.delete();
        base_addr  = base;
        word_count = CNT_W'(n);
        start      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        cyc = 0; sent = 0; last_hs = 0;
        while (cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) break;
            if (sent < n) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : pat[(cyc - 1) % patlen];
                in_data  = words[sent];
                if (in_valid && in_ready) begin
                    sent++;
                    last_hs = cyc;
                end
            end else begin
                in_valid = ($urandom_range(0, 1) == 1);
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;

        exp_done = (range_err || n == 0) ? 1 : last_hs + n + 1;
        chk({name, ".done_cycle"}, 32'(cyc), 32'(exp_done));
        chk({name, ".done"},       32'(done), 32'd1);
        chk({name, ".busy"},       32'(busy), 32'd0);
        chk({name, ".error"},      32'(error), 32'(exp_err));
        chk({name, ".cpu_run"},    32'(cpu_run), 32'(!exp_err));
        chk({name, ".checksum"},   checksum, exp_sum);
        chk({name, ".in_ready"},   32'(in_ready), 32'd0);
        chk({name, ".writes"},     32'(wr_log.size()), 32'(exp_writes));
        if (wr_log.size() == exp_writes) begin
            for (int i = 0; i < exp_writes; i++) begin
                e = wr_log[i];
                chk({name, ".wr_addr"}, e[63:32], base + 32'(i));
                chk({name, ".wr_data"}, e[31:0], words[i]);
            end
        end
    endtask

    initial begin
        logic [31:0] b;
        int          n;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b1; in_data = 32'h1234_5678;

        // Reset state: everything low, including the combinational write strobe.
        #12;
        chk("rst.busy",    32'(busy), 32'd0);
        chk("rst.done",    32'(done), 32'd0);
        chk("rst.error",   32'(error), 32'd0);
        chk("rst.cpu_run", 32'(cpu_run), 32'd0);
        chk("rst.ready",   32'(in_ready), 32'd0);
        chk("rst.we",      32'(mem_write_enable), 32'd0);
        chk("rst.csum",    checksum, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // 23 words at base 0, valid held high.
        words.delete();
        for (int i = 0; i < 23; i++) words.push_back(32'h2008_0001 + 32'(i) * 32'h0002_A001);
        words[22] = 32'h2042_0020;
        run_case("load23", 32'd0, 23, 1'b0, 16'h0001, 1);

        // Region runs past the end of memory.
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back($urandom);
        run_case("range", 32'd1010, 20, 1'b0, 16'h0001, 1);

        // Empty load.
        words.delete();
        run_case("zero", 32'd5, 0, 1'b0, 16'h0001, 1);

        // Bubbly stream 1,0,0,1,1,0,1 at base 100.
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        run_case("toggle", 32'd100, 4, 1'b0, 16'b0000_0000_0101_1001, 7);

        // Same load with the memory corrupting address 101.
        corrupt_addr = 101;
        run_case("corrupt", 32'd100, 4, 1'b0, 16'b0000_0000_0101_1001, 7);
        corrupt_addr = -1;

        // Region ending exactly at the top of memory, then one word past it.
        words.delete();
        for (int i = 0; i < 10; i++) words.push_back($urandom);
        run_case("edge_fit", 32'd1014, 10, 1'b1, 16'h0001, 1);
        run_case("edge_over", 32'd1015, 10, 1'b1, 16'h0001, 1);

        // Base so large that a 32-bit sum would wrap below MAX_WORDS.
        words.delete();
        for (int i = 0; i < 32; i++) words.push_back($urandom);
        run_case("wrap", 32'hFFFF_FFF0, 32, 1'b0, 16'h0001, 1);

        // Reset after 3 of 8 words, then a clean 2-word load.
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back($urandom);
        @(negedge clk);
        wr_log.delete();
        base_addr = 32'd200; word_count = CNT_W'(8); start = 1'b1; in_valid = 1'b0;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = words[0];
        @(negedge clk); in_data = words[1];
        @(negedge clk); in_data = words[2];
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.writes",  32'(wr_log.size()), 32'd3);
        chk("midrst.busy",    32'(busy), 32'd0);
        chk("midrst.done",    32'(done), 32'd0);
        chk("midrst.ready",   32'(in_ready), 32'd0);
        chk("midrst.we",      32'(mem_write_enable), 32'd0);
        chk("midrst.waddr",   mem_write_address, 32'h0);
        chk("midrst.wdata",   mem_data_in, 32'h0);
        chk("midrst.csum",    checksum, 32'h0);
        chk("midrst.cpu_run", 32'(cpu_run), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        words.delete();
        for (int i = 0; i < 2; i++) words.push_back($urandom);
        run_case("after_rst", 32'd300, 2, 1'b0, 16'h0001, 1);

        // Randomized in-range loads with random bubbles.
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 30);
            b = 32'($urandom_range(0, MAX_WORDS - n));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_case("random", b, n, 1'b1, 16'h0001, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Initiator/writer for the word-addressed instruction and data memories.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive addresses starting at a base address, using the memory's write port.
- Reads the loaded region back through the combinational read port and checks that the readback sum matches the sum of the written words.
- Holds the processor out of execution (cpu_run low) until a load completes cleanly.

Parameters:
- MAX_WORDS, 1024: memory depth in words; the region base_addr..base_addr+word_count-1 must lie below this.
- CNT_W, 11: width of word_count; CNT_W = clog2(MAX_WORDS)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled in IDLE and DONE.
- base_addr  in  32  first word address; latched on start.
- word_count  in  CNT_W  number of words; latched on start.
- in_valid  in  1  stream word present.
- in_ready  out  1  loader accepts the stream word.
- in_data  in  32  stream word.
- mem_write_enable  out  1  to the memory write_enable.
- mem_write_address  out  32  to the memory write_address.
- mem_data_in  out  32  to the memory data_in.
- mem_read_address  out  32  to the memory read_address.
- mem_data_out  in  32  from the memory data_out (combinational read).
- busy  out  1  high in LOAD and VERIFY.
- done  out  1  high in DONE.
- error  out  1  range or checksum failure; valid while done is high.
- checksum  out  32  running sum of loaded words, mod 2^32.
- cpu_run  out  1  high in DONE when error is low.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; index, load_sum, read_sum, checksum and error clear to 0.
  - All outputs are 0, including mem_write_enable, in_ready and cpu_run.
  - Reset mid-LOAD abandons the load; words already written stay in memory.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE, or DONE with start=1: latch base_addr and word_count; clear index, sums, error and cpu_run.
  - If base_addr + word_count > MAX_WORDS (32-bit compare, no wrap): go to DONE with error=1. No memory writes occur.
  - Else if word_count == 0: go to DONE with error=0 and checksum=0.
  - Else: go to LOAD.
- LOAD:
  - in_ready=1.
  - mem_write_enable = in_valid (combinational); mem_write_address = base + index; mem_data_in = in_data.
  - On each handshake: the memory captures the word at this posedge; load_sum += in_data; index += 1.
  - in_valid low: no write and no change. Bubbles of any length are allowed.
  - On the handshake with index == count-1: index ← 0, go to VERIFY.
  - start is ignored outside IDLE and DONE.
- VERIFY:
  - in_ready=0; mem_write_enable=0.
  - mem_read_address = base + index (driven from registers).
  - Every cycle: read_sum += mem_data_out; index += 1.
  - At index == count-1, take the final accumulate, then go to DONE with error = (final read_sum != load_sum).
  - Takes exactly count cycles.
- DONE:
  - done=1; cpu_run = !error; checksum holds load_sum.
  - Stays in DONE until reset or start.
- Latency: N words with in_valid held high gives N LOAD cycles, then N VERIFY cycles; done rises on cycle 2N+1 after the start cycle.
- Arithmetic: all sums wrap mod 2^32; address = base_addr + zero-extended index.
- Simultaneous events:
  - start and in_valid in the same IDLE cycle: the word is not accepted (in_ready=0 in IDLE).
  - in_valid in VERIFY or DONE: ignored; in_ready=0.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/LOAD/VERIFY/DONE);
  - the MAX_WORDS default;
  - the ADDR_W=32 constant.
- One natural sub-module, addr_sum_counter: index register plus 32-bit wrap accumulator with clear/enable. Instantiated twice, for the load sum and the read sum.

Test Plan:
- Load 23 words 0x20080001..0x20420020 at base 0, in_valid held high: 23 writes to addresses 0..22, then 23 read cycles; done on cycle 47 with error=0, cpu_run=1, checksum equal to the mod-2^32 sum of the words.
- base=1010, count=20: done on the next cycle with error=1, cpu_run=0; mem_write_enable never asserts.
- count=0, base=5: DONE with error=0 and checksum=0; cpu_run=1.
- Load 4 words at base 100 with in_valid toggling 1,0,0,1,1,0,1: writes only on valid cycles at addresses 100..103 in order; error=0.
- Testbench memory model corrupts address 101 after the write: VERIFY sum mismatches, so error=1 and cpu_run=0.
- Assert rst_n low after 3 of 8 words: all outputs 0 immediately; a subsequent start with count=2 completes normally with error=0.
